// File: rtl/coord_plotter_pkg.sv
// coord_plotter_pkg
//   Shared constants and types for the 1-bpp framebuffer writer and its neighbours
//   (VGA scan stage, bench). The framebuffer is 640x480 pixels packed 32 per word,
//   and is addressed as bytes on BRAM port B.
//   Contents: screen geometry, framebuffer word count, address widths, the writer
//   FSM state encoding and the pixel-location record produced by coord_to_fbaddr.
package coord_plotter_pkg;

   localparam int H_RES    = 640;
   localparam int V_RES    = 480;
   localparam int FB_WORDS = 9600;   // 640*480/32
   localparam int WORD_AW  = 14;     // word index width
   localparam int BYTE_AW  = 16;     // BRAM byte address width
   localparam int PIX_AW   = 19;     // linear pixel index width
   localparam int X_W      = 11;     // signed Cartesian x
   localparam int Y_W      = 10;     // signed Cartesian y
   localparam int CR_W     = 12;     // signed screen column/row

   localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(FB_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CALC = 3'd1,
      ST_RD   = 3'd2,
      ST_WAIT = 3'd3,
      ST_WR   = 3'd4,
      ST_CLR  = 3'd5
   } plot_state_e;

   typedef struct packed {
      logic               oob;      // point falls outside the visible frame
      logic [WORD_AW-1:0] word;     // framebuffer word holding the pixel
      logic [4:0]         bit_idx;  // pixel position inside that word
   } fb_loc_t;

   function automatic logic [BYTE_AW-1:0] word_to_byte_addr(input logic [WORD_AW-1:0] w);
      return {w, 2'b00};
   endfunction

endpackage

// File: rtl/coord_to_fbaddr.sv
// coord_to_fbaddr
//   Combinational map from a signed Cartesian point (origin at screen centre, +y up)
//   to a framebuffer word/bit, with an off-screen flag.
//   Ports:
//     coord_x  in  11  signed Cartesian x
//     coord_y  in  10  signed Cartesian y
//     loc      out     {oob, word, bit_idx}; word/bit_idx are meaningless when oob=1
module coord_to_fbaddr
   import coord_plotter_pkg::*;
#(
   parameter int X_ORIGIN = 320,
   parameter int Y_ORIGIN = 239
) (
   input  logic [X_W-1:0] coord_x,
   input  logic [Y_W-1:0] coord_y,
   output fb_loc_t        loc
);

   logic [CR_W-1:0]   col;
   logic [CR_W-1:0]   row;
   logic [PIX_AW-1:0] row_ext;
   logic [PIX_AW-1:0] pix_n;

   always_comb begin
      // Sign-extend into 12 bits; two's-complement arithmetic keeps the sign in bit 11.
      col = {coord_x[X_W-1], coord_x} + CR_W'(X_ORIGIN);
      row = CR_W'(Y_ORIGIN) - {{(CR_W-Y_W){coord_y[Y_W-1]}}, coord_y};

      // Negative values have bit 11 set; the magnitude checks cover the far edges.
      loc.oob = col[CR_W-1] || row[CR_W-1] ||
                (col[CR_W-2:0] >= 11'(H_RES)) || (row[CR_W-2:0] >= 11'(V_RES));

      // row*640 as two shifts; only meaningful when on-screen, where row < 480.
      row_ext = {10'd0, row[8:0]};
      pix_n   = (row_ext << 9) + (row_ext << 7) + {9'd0, col[9:0]};

      loc.word    = pix_n[PIX_AW-1:5];
      loc.bit_idx = pix_n[4:0];
   end

endmodule

// File: rtl/coord_plotter.sv
// coord_plotter
//   Writes single pixels into the 1-bpp framebuffer BRAM (port B) by read-modify-write,
//   and can zero the whole frame.
//   Ports:
//     clk_25MHz, reset           clock; asynchronous active-high reset
//     coord_valid/coord_ready    point request handshake
//     coord_x, coord_y           signed Cartesian point (11/10 bit)
//     coord_draw                 1 = set pixel, 0 = erase pixel
//     clear_req                  pulse: zero the entire framebuffer
//     busy                       FSM not idle
//     done                       pulse when a point or a clear completes
//     err_oob                    pulse when a point is dropped as off-screen
//     bram_en/we/addr/din        registered port-B controls (byte address, 32-bit word)
//     bram_dout                  port-B read data, READ_LAT cycles after a read
//
//   Handshake: a point transfers on a cycle where coord_valid && coord_ready. coord_ready
//   is high only in IDLE with no clear pending, so it does not depend on coord_valid.
//   Point fields are captured at transfer; later input changes are ignored.
module coord_plotter
   import coord_plotter_pkg::*;
#(
   parameter int X_ORIGIN = 320,
   parameter int Y_ORIGIN = 239,
   parameter int READ_LAT = 1
) (
   input  logic               clk_25MHz,
   input  logic               reset,
   input  logic               coord_valid,
   output logic               coord_ready,
   input  logic [X_W-1:0]     coord_x,
   input  logic [Y_W-1:0]     coord_y,
   input  logic               coord_draw,
   input  logic               clear_req,
   output logic               busy,
   output logic               done,
   output logic               err_oob,
   output logic               bram_en,
   output logic               bram_we,
   output logic [BYTE_AW-1:0] bram_addr,
   output logic [31:0]        bram_din,
   input  logic [31:0]        bram_dout
);

   localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

   plot_state_e        state_q, state_d;
   logic               clr_pend_q, clr_pend_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic               draw_q, draw_d;
   logic [4:0]         bit_q, bit_d;
   logic [1:0]         wait_cnt_q, wait_cnt_d;
   logic [WORD_AW-1:0] clr_cnt_q, clr_cnt_d;
   logic               bram_en_q, bram_en_d;
   logic               bram_we_q, bram_we_d;
   logic [BYTE_AW-1:0] bram_addr_q, bram_addr_d;
   logic [31:0]        bram_din_q, bram_din_d;
   logic               done_q, done_d;

   fb_loc_t            loc;
   logic [WORD_AW-1:0] clr_nxt;
   logic [31:0]        bit_mask;

   // Mapping works on the captured point, so its result is stable across CALC.
   coord_to_fbaddr #(
      .X_ORIGIN (X_ORIGIN),
      .Y_ORIGIN (Y_ORIGIN)
   ) u_addr (
      .coord_x (x_q),
      .coord_y (y_q),
      .loc     (loc)
   );

   assign coord_ready = (state_q == ST_IDLE) && !clr_pend_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign bram_en     = bram_en_q;
   assign bram_we     = bram_we_q;
   assign bram_addr   = bram_addr_q;
   assign bram_din    = bram_din_q;

   always_comb begin
      state_d     = state_q;
      clr_pend_d  = clr_pend_q | clear_req;
      x_d         = x_q;
      y_d         = y_q;
      draw_d      = draw_q;
      bit_d       = bit_q;
      wait_cnt_d  = wait_cnt_q;
      clr_cnt_d   = clr_cnt_q;
      bram_en_d   = 1'b0;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = 32'd0;
      done_d      = 1'b0;
      err_oob     = 1'b0;
      clr_nxt     = clr_cnt_q + WORD_AW'(1);
      bit_mask    = 32'd1 << bit_q;

      // Port-B controls are computed for the state being entered, so the
      // registered outputs line up with that state.
      unique case (state_q)
         ST_IDLE: begin
            if (clr_pend_q) begin
               state_d     = ST_CLR;
               clr_cnt_d   = '0;
               bram_en_d   = 1'b1;
               bram_we_d   = 1'b1;
               bram_addr_d = word_to_byte_addr('0);
            end else if (coord_valid) begin
               state_d = ST_CALC;
               x_d     = coord_x;
               y_d     = coord_y;
               draw_d  = coord_draw;
            end
         end

         ST_CALC: begin
            if (loc.oob) begin
               err_oob = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d     = ST_RD;
               bit_d       = loc.bit_idx;
               bram_en_d   = 1'b1;
               bram_addr_d = word_to_byte_addr(loc.word);
            end
         end

         ST_RD: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
         end

         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               // bram_dout is valid this cycle; fold the pixel in as the write data.
               state_d    = ST_WR;
               bram_en_d  = 1'b1;
               bram_we_d  = 1'b1;
               bram_din_d = draw_q ? (bram_dout | bit_mask) : (bram_dout & ~bit_mask);
               done_d     = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end

         ST_WR: begin
            state_d = ST_IDLE;
         end

         ST_CLR: begin
            // Further clear requests during a clear are absorbed.
            clr_pend_d = 1'b1;
            if (clr_cnt_q == LAST_WORD) begin
               state_d    = ST_IDLE;
               clr_pend_d = 1'b0;
            end else begin
               clr_cnt_d   = clr_nxt;
               bram_en_d   = 1'b1;
               bram_we_d   = 1'b1;
               bram_addr_d = word_to_byte_addr(clr_nxt);
               done_d      = (clr_nxt == LAST_WORD);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         clr_pend_q  <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         draw_q      <= 1'b0;
         bit_q       <= '0;
         wait_cnt_q  <= '0;
         clr_cnt_q   <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_pend_q  <= clr_pend_d;
         x_q         <= x_d;
         y_q         <= y_d;
         draw_q      <= draw_d;
         bit_q       <= bit_d;
         wait_cnt_q  <= wait_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_coord_plotter.sv
// tb_coord_plotter
//   Bench for coord_plotter. Two instances (READ_LAT=1 and READ_LAT=2) each drive their
//   own BRAM model; 'sel' picks which one the stimulus and checks address.
module tb_coord_plotter;
   import coord_plotter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_25MHz = 1'b0;
   always #20 clk_25MHz = ~clk_25MHz;

   logic        reset;
   logic        coord_valid, clear_req, coord_draw;
   logic [10:0] coord_x;
   logic [9:0]  coord_y;
   logic        scramble;
   int          sel;

   logic v1, v2, c1, c2;
   assign v1 = coord_valid && (sel == 0);
   assign v2 = coord_valid && (sel == 1);
   assign c1 = clear_req && (sel == 0);
   assign c2 = clear_req && (sel == 1);

   logic        r1, b1, d1, o1, en1, we1;
   logic [15:0] a1;
   logic [31:0] di1, do1;
   logic        r2, b2, d2, o2, en2, we2;
   logic [15:0] a2;
   logic [31:0] di2, do2;

   coord_plotter #(.READ_LAT(1)) dut1 (
      .clk_25MHz(clk_25MHz), .reset(reset), .coord_valid(v1), .coord_ready(r1),
      .coord_x(coord_x), .coord_y(coord_y), .coord_draw(coord_draw), .clear_req(c1),
      .busy(b1), .done(d1), .err_oob(o1), .bram_en(en1), .bram_we(we1),
      .bram_addr(a1), .bram_din(di1), .bram_dout(do1));

   coord_plotter #(.READ_LAT(2)) dut2 (
      .clk_25MHz(clk_25MHz), .reset(reset), .coord_valid(v2), .coord_ready(r2),
      .coord_x(coord_x), .coord_y(coord_y), .coord_draw(coord_draw), .clear_req(c2),
      .busy(b2), .done(d2), .err_oob(o2), .bram_en(en2), .bram_we(we2),
      .bram_addr(a2), .bram_din(di2), .bram_dout(do2));

   // ---------------- BRAM models (read data valid exactly READ_LAT cycles later) ----------------
   localparam logic [31:0] JUNK = 32'hA5A5_5A5A;
   logic [31:0] mem1 [FB_WORDS];
   logic [31:0] mem2 [FB_WORDS];
   logic [31:0] rd2_s1;
   logic [13:0] idx1, idx2;
   assign idx1 = a1[15:2];
   assign idx2 = a2[15:2];

   always @(posedge clk_25MHz) begin
      if (scramble) begin
         for (int i = 0; i < FB_WORDS; i++) mem1[i] <= $urandom;
      end else if (en1 && we1 && idx1 < FB_WORDS) begin
         mem1[idx1] <= di1;
      end
      do1 <= (en1 && !we1 && idx1 < FB_WORDS) ? mem1[idx1] : JUNK;
   end

   always @(posedge clk_25MHz) begin
      if (scramble) begin
         for (int i = 0; i < FB_WORDS; i++) mem2[i] <= $urandom;
      end else if (en2 && we2 && idx2 < FB_WORDS) begin
         mem2[idx2] <= di2;
      end
      rd2_s1 <= (en2 && !we2 && idx2 < FB_WORDS) ? mem2[idx2] : JUNK;
      do2    <= rd2_s1;
   end

   // selected DUT view
   logic        ready_m, busy_m, done_m, oob_m, en_m, we_m;
   logic [15:0] addr_m;
   logic [31:0] din_m;
   always_comb begin
      if (sel == 0) begin
         ready_m = r1; busy_m = b1; done_m = d1; oob_m = o1;
         en_m = en1; we_m = we1; addr_m = a1; din_m = di1;
      end else begin
         ready_m = r2; busy_m = b2; done_m = d2; oob_m = o2;
         en_m = en2; we_m = we2; addr_m = a2; din_m = di2;
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (READ_LAT=%0d): got 0x%0h, expected 0x%0h", name, sel + 1, act, exp);
      end
   endtask

   // Reference framebuffer: one 32-bit word per 32 horizontally adjacent pixels.
   logic [31:0] ref_mem [FB_WORDS];

   task automatic ref_zero();
      for (int i = 0; i < FB_WORDS; i++) ref_mem[i] = 32'd0;
   endtask

   // Plain-arithmetic model of one point request.
   task automatic model_point(input int x, input int y, input bit draw,
                              output bit oob, output logic [15:0] addr, output logic [31:0] data);
      int col, row, n;
      col  = x + 320;
      row  = 239 - y;
      oob  = (col < 0) || (col >= 640) || (row < 0) || (row >= 480);
      addr = 16'd0;
      data = 32'd0;
      if (!oob) begin
         n    = row * 640 + col;
         data = ref_mem[n / 32];
         data[n % 32] = draw;
         ref_mem[n / 32] = data;
         addr = 16'((n / 32) * 4);
      end
   endtask

   // ---------------- driver / monitor ----------------
   int          obs_rd_n, obs_wr_n, obs_done_n, obs_oob_n;
   int          obs_rd_cyc, obs_wr_cyc, obs_done_cyc, obs_oob_cyc;
   logic [15:0] obs_rd_addr, obs_wr_addr;
   logic [31:0] obs_wr_data;
   bit          obs_xfer_ok;

   // Cycle 1 is the cycle right after the transfer edge.
   task automatic observe(input int ncyc);
      obs_rd_n = 0; obs_wr_n = 0; obs_done_n = 0; obs_oob_n = 0;
      obs_rd_cyc = -1; obs_wr_cyc = -1; obs_done_cyc = -1; obs_oob_cyc = -1;
      obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_25MHz);
         if (en_m && !we_m) begin obs_rd_n++; obs_rd_cyc = c; obs_rd_addr = addr_m; end
         if (en_m && we_m) begin
            obs_wr_n++; obs_wr_cyc = c; obs_wr_addr = addr_m; obs_wr_data = din_m;
         end
         if (done_m) begin obs_done_n++; obs_done_cyc = c; end
         if (oob_m)  begin obs_oob_n++;  obs_oob_cyc = c;  end
      end
      @(posedge clk_25MHz); #1;
   endtask

   task automatic send_point(input int x, input int y, input bit draw);
      coord_x = 11'(x); coord_y = 10'(y); coord_draw = draw; coord_valid = 1'b1;
      obs_xfer_ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_25MHz);
         if (ready_m) begin obs_xfer_ok = 1'b1; break; end
      end
      @(posedge clk_25MHz); #1;
      coord_valid = 1'b0;
      coord_x = 11'($urandom); coord_y = 10'($urandom); coord_draw = 1'($urandom);
      observe(12);
   endtask

   task automatic check_point(input string tag, input bit e_oob,
                              input logic [15:0] e_addr, input logic [31:0] e_data);
      int rl;
      rl = sel + 1;
      check({tag, "_xfer"}, 32'(obs_xfer_ok), 32'd1);
      if (e_oob) begin
         check({tag, "_oob_pulses"}, 32'(obs_oob_n), 32'd1);
         check({tag, "_oob_cycle"}, 32'(obs_oob_cyc), 32'd1);
         check({tag, "_oob_bram_acc"}, 32'(obs_rd_n + obs_wr_n), 32'd0);
         check({tag, "_oob_done"}, 32'(obs_done_n), 32'd0);
      end else begin
         check({tag, "_reads"}, 32'(obs_rd_n), 32'd1);
         check({tag, "_rd_addr"}, 32'(obs_rd_addr), 32'(e_addr));
         check({tag, "_rd_cycle"}, 32'(obs_rd_cyc), 32'd2);
         check({tag, "_writes"}, 32'(obs_wr_n), 32'd1);
         check({tag, "_wr_addr"}, 32'(obs_wr_addr), 32'(e_addr));
         check({tag, "_wr_data"}, obs_wr_data, e_data);
         check({tag, "_wr_cycle"}, 32'(obs_wr_cyc), 32'(3 + rl));
         check({tag, "_done_n"}, 32'(obs_done_n), 32'd1);
         check({tag, "_done_cycle"}, 32'(obs_done_cyc), 32'(3 + rl));
         check({tag, "_no_oob"}, 32'(obs_oob_n), 32'd0);
      end
   endtask

   // Full clear, with a second clear_req mid-way that must be absorbed.
   task automatic run_clear();
      int wr_n, order_err, data_err, rd_err, done_n, ready_err;
      bit done_last;
      wr_n = 0; order_err = 0; data_err = 0; rd_err = 0; done_n = 0; ready_err = 0;
      done_last = 1'b0;
      clear_req = 1'b1;
      @(posedge clk_25MHz); #1;
      clear_req = 1'b0;
      for (int c = 0; c < FB_WORDS + 20; c++) begin
         @(negedge clk_25MHz);
         if (en_m && we_m) begin
            if (addr_m !== 16'(wr_n * 4)) order_err++;
            if (din_m !== 32'd0) data_err++;
            if (done_m) done_last = (wr_n == FB_WORDS - 1);
            wr_n++;
         end else if (en_m) begin
            rd_err++;
         end
         if (done_m) done_n++;
         if (done_n == 0 && ready_m) ready_err++;
         clear_req = (c == 100);
      end
      clear_req = 1'b0;
      @(posedge clk_25MHz); #1;
      check("clr_write_count", 32'(wr_n), 32'(FB_WORDS));
      check("clr_addr_order_errs", 32'(order_err), 32'd0);
      check("clr_nonzero_data", 32'(data_err), 32'd0);
      check("clr_reads", 32'(rd_err), 32'd0);
      check("clr_done_count", 32'(done_n), 32'd1);
      check("clr_done_on_last", 32'(done_last), 32'd1);
      check("clr_ready_during", 32'(ready_err), 32'd0);
      check("clr_ready_after", 32'(ready_m), 32'd1);
      ref_zero();
   endtask

   task automatic compare_fb(input string tag);
      int mism;
      mism = 0;
      for (int i = 0; i < FB_WORDS; i++) begin
         if (sel == 0) begin
            if (mem1[i] !== ref_mem[i]) mism++;
         end else begin
            if (mem2[i] !== ref_mem[i]) mism++;
         end
      end
      check(tag, 32'(mism), 32'd0);
   endtask

   // clear_req lands while a point waits for read data.
   task automatic test_clear_during_wait();
      bit          oob;
      logic [15:0] pa, p2a;
      logic [31:0] pd, p2d;
      logic [15:0] p1_addr;
      logic [31:0] p1_data;
      bit          p1_done, got_ready;
      int          wr_n, clr_err, done_n, early;
      model_point(40, -20, 1'b1, oob, pa, pd);
      coord_x = 11'(40); coord_y = 10'(-20); coord_draw = 1'b1; coord_valid = 1'b1;
      obs_xfer_ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_25MHz);
         if (ready_m) begin obs_xfer_ok = 1'b1; break; end
      end
      @(posedge clk_25MHz); #1;                    // cycle 1 (CALC)
      coord_x = 11'(-100); coord_y = 10'(50);      // next point, valid held high
      @(posedge clk_25MHz); #1;                    // cycle 2 (RD)
      @(posedge clk_25MHz); #1;                    // cycle 3 (WAIT)
      clear_req = 1'b1;
      @(posedge clk_25MHz); #1;
      clear_req = 1'b0;
      p1_addr = '0; p1_data = '0; p1_done = 1'b0; got_ready = 1'b0;
      wr_n = 0; clr_err = 0; done_n = 0; early = 0;
      for (int c = 0; c < FB_WORDS + 40; c++) begin
         @(negedge clk_25MHz);
         if (en_m && we_m) begin
            if (wr_n == 0) begin
               p1_addr = addr_m; p1_data = din_m; p1_done = done_m;
            end else if (addr_m !== 16'((wr_n - 1) * 4) || din_m !== 32'd0) begin
               clr_err++;
            end
            wr_n++;
         end
         if (done_m) done_n++;
         if (ready_m) begin
            if (done_n < 2) early++;
            else begin got_ready = 1'b1; break; end
         end
      end
      check("cdw_xfer", 32'(obs_xfer_ok), 32'd1);
      check("cdw_p1_addr", 32'(p1_addr), 32'(pa));
      check("cdw_p1_data", p1_data, pd);
      check("cdw_p1_done", 32'(p1_done), 32'd1);
      check("cdw_write_count", 32'(wr_n), 32'(FB_WORDS + 1));
      check("cdw_clear_errs", 32'(clr_err), 32'd0);
      check("cdw_done_count", 32'(done_n), 32'd2);
      check("cdw_early_ready", 32'(early), 32'd0);
      check("cdw_ready_after", 32'(got_ready), 32'd1);
      ref_zero();
      model_point(-100, 50, 1'b1, oob, p2a, p2d);
      @(posedge clk_25MHz); #1;                    // held point transfers here
      coord_valid = 1'b0;
      observe(12);
      obs_xfer_ok = got_ready;
      check_point("cdw_p2", oob, p2a, p2d);
   endtask

   // Reset asserted while the clear is writing word 5000.
   task automatic test_reset_mid_clear();
      bit          hit, oob;
      int          done_n, late_done;
      logic [15:0] ea;
      logic [31:0] ed;
      hit = 1'b0; done_n = 0; late_done = 0;
      clear_req = 1'b1;
      @(posedge clk_25MHz); #1;
      clear_req = 1'b0;
      for (int c = 0; c < FB_WORDS + 20; c++) begin
         @(negedge clk_25MHz);
         if (done_m) done_n++;
         if (en_m && we_m && addr_m == 16'(5000 * 4)) begin hit = 1'b1; break; end
      end
      reset = 1'b1;
      #1;
      check("rst_mid_hit_5000", 32'(hit), 32'd1);
      check("rst_mid_no_done_before", 32'(done_n), 32'd0);
      check("rst_mid_en", 32'(en_m), 32'd0);
      check("rst_mid_we", 32'(we_m), 32'd0);
      check("rst_mid_addr", 32'(addr_m), 32'd0);
      check("rst_mid_din", din_m, 32'd0);
      check("rst_mid_done", 32'(done_m), 32'd0);
      check("rst_mid_busy", 32'(busy_m), 32'd0);
      check("rst_mid_ready", 32'(ready_m), 32'd1);
      @(posedge clk_25MHz); @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_25MHz);
         if (done_m || busy_m || en_m || !ready_m) late_done++;
      end
      check("rst_mid_quiet_after", 32'(late_done), 32'd0);
      @(posedge clk_25MHz); #1;
      // words 0..4999 are now zero; everything above was already zero
      ref_zero();
      model_point(0, 0, 1'b1, oob, ea, ed);
      send_point(0, 0, 1'b1);
      check_point("rst_mid_point", oob, ea, ed);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          x;
      int          y;
      bit          draw;
      bit          oob;
      logic [15:0] addr;
      logic [31:0] data;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      bit          m_oob;
      logic [15:0] m_addr;
      logic [31:0] m_data;
      int          rx, ry;
      bit          rd;

      vecs[0]  = '{0,    0,    1'b1, 1'b0, 16'd19160, 32'h0000_0001};
      vecs[1]  = '{-320, 239,  1'b1, 1'b0, 16'd0,     32'h0000_0001};
      vecs[2]  = '{-319, 239,  1'b1, 1'b0, 16'd0,     32'h0000_0003};
      vecs[3]  = '{-320, 239,  1'b0, 1'b0, 16'd0,     32'h0000_0002};
      vecs[4]  = '{319,  -240, 1'b1, 1'b0, 16'd38396, 32'h8000_0000};
      vecs[5]  = '{320,  0,    1'b1, 1'b1, 16'd0,     32'h0};
      vecs[6]  = '{0,    240,  1'b1, 1'b1, 16'd0,     32'h0};
      vecs[7]  = '{-321, 0,    1'b0, 1'b1, 16'd0,     32'h0};
      vecs[8]  = '{0,    -241, 1'b1, 1'b1, 16'd0,     32'h0};
      vecs[9]  = '{5,    7,    1'b1, 1'b0, 16'd18600, 32'h0000_0020};
      vecs[10] = '{0,    0,    1'b0, 1'b0, 16'd19160, 32'h0000_0000};
      vecs[11] = '{-289, 239,  1'b1, 1'b0, 16'd0,     32'h8000_0002};
      vecs[12] = '{-288, 239,  1'b1, 1'b0, 16'd4,     32'h0000_0001};

      reset = 1'b1; coord_valid = 1'b0; clear_req = 1'b0; coord_draw = 1'b0;
      coord_x = '0; coord_y = '0; scramble = 1'b0; sel = 0;

      for (int s = 0; s < 2; s++) begin
         sel   = s;
         reset = 1'b1;
         repeat (3) @(posedge clk_25MHz);
         #1 scramble = 1'b1;
         @(posedge clk_25MHz); #1;
         scramble = 1'b0;
         @(negedge clk_25MHz);
         check("reset_ready", 32'(ready_m), 32'd1);
         check("reset_busy", 32'(busy_m), 32'd0);
         check("reset_done", 32'(done_m), 32'd0);
         check("reset_oob", 32'(oob_m), 32'd0);
         check("reset_en", 32'(en_m), 32'd0);
         check("reset_we", 32'(we_m), 32'd0);
         check("reset_addr", 32'(addr_m), 32'd0);
         check("reset_din", din_m, 32'd0);
         reset = 1'b0;
         @(posedge clk_25MHz); #1;

         run_clear();
         compare_fb("fb_after_clear");

         for (int i = 0; i < NV; i++) begin
            model_point(vecs[i].x, vecs[i].y, vecs[i].draw, m_oob, m_addr, m_data);
            send_point(vecs[i].x, vecs[i].y, vecs[i].draw);
            check_point($sformatf("vec%0d", i), vecs[i].oob, vecs[i].addr, vecs[i].data);
         end

         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               rx = $urandom_range(0, 63) - 320;   // crowd a few words to hit same-word RMWs
               ry = 239 - $urandom_range(0, 1);
            end else begin
               rx = $urandom_range(0, 760) - 380;
               ry = $urandom_range(0, 580) - 290;
            end
            rd = 1'($urandom_range(0, 1));
            model_point(rx, ry, rd, m_oob, m_addr, m_data);
            send_point(rx, ry, rd);
            check_point($sformatf("rnd%0d", i), m_oob, m_addr, m_data);
         end
         compare_fb("fb_after_points");

         test_clear_during_wait();
         test_reset_mid_clear();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
